// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined CPU.
// Holds the opcode map, instruction field positions and datapath widths.
package cpu_pkg;

    localparam int PC_W  = 16;
    localparam int INS_W = 16;

    typedef enum logic [4:0] {
        OP_NOP  = 5'd0,
        OP_ADD  = 5'd1,
        OP_SUB  = 5'd2,
        OP_MOVI = 5'd3,
        OP_LODR = 5'd4,
        OP_STO  = 5'd5,
        OP_JMP  = 5'd6,
        OP_JEQ  = 5'd7
    } opcode_e;

    localparam int OP_MSB      = 15;
    localparam int OP_LSB      = 11;
    localparam int RA_MSB      = 10;
    localparam int RA_LSB      = 8;
    localparam int RB_MSB      = 7;
    localparam int RB_LSB      = 5;
    localparam int JMP_OFF_MSB = 10;
    localparam int JEQ_OFF_MSB = 4;

    localparam logic [INS_W-1:0] NOP_INS = 16'h0000;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: ROM address/data, hazard and redirect controls,
// and the IF/ID register contents handed to decode.
interface fetch_unit_if #(
    parameter int PC_W  = 16,
    parameter int INS_W = 16
) ();

    logic [PC_W-1:0]  imem_addr;
    logic [INS_W-1:0] imem_ins;
    logic             stall;
    logic             ex_redirect;
    logic [PC_W-1:0]  ex_target;
    logic [INS_W-1:0] if_id_ins;
    logic [PC_W-1:0]  if_id_pc;
    logic             if_id_valid;
    logic             halted;
    logic [15:0]      fetch_count;

    modport master (
        output imem_addr,
        input  imem_ins,
        input  stall,
        input  ex_redirect,
        input  ex_target,
        output if_id_ins,
        output if_id_pc,
        output if_id_valid,
        output halted,
        output fetch_count
    );

    modport slave (
        input  imem_addr,
        output imem_ins,
        output stall,
        output ex_redirect,
        output ex_target,
        input  if_id_ins,
        input  if_id_pc,
        input  if_id_valid,
        input  halted,
        input  fetch_count
    );

endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register. A flush inserts a NOP bubble and outranks hold;
// hold keeps the current contents; load captures a new fetch.
module if_id_reg #(
    parameter int PC_W  = 16,
    parameter int INS_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             hold,
    input  logic             flush,
    input  logic [INS_W-1:0] ins,
    input  logic [PC_W-1:0]  pc,
    output logic [INS_W-1:0] ins_p1,
    output logic [PC_W-1:0]  pc_p1,
    output logic             vld_p1
);

    import cpu_pkg::*;

    // IF -> ID boundary
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ins_p1 <= NOP_INS;
            pc_p1  <= '0;
            vld_p1 <= 1'b0;
        end else if (flush) begin
            ins_p1 <= NOP_INS;
            vld_p1 <= 1'b0;
        end else if (hold) begin
            ins_p1 <= ins_p1;
            pc_p1  <= pc_p1;
            vld_p1 <= vld_p1;
        end else if (load) begin
            ins_p1 <= ins;
            pc_p1  <= pc;
            vld_p1 <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, pre-decodes JMP so it costs no bubble,
// and obeys stall, EX redirect and the end-of-ROM halt.
module fetch_unit #(
    parameter int PC_W       = 16,
    parameter int INS_W      = 16,
    parameter int IMEM_DEPTH = 30,
    parameter int RESET_PC   = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);

    import cpu_pkg::*;

    logic [PC_W-1:0]         pc_p0;
    logic                    halted_q;
    logic [15:0]             count_q;
    logic                    is_jmp;
    logic                    past_end;
    logic signed [PC_W-1:0]  jmp_off;
    logic [PC_W-1:0]         jmp_target;
    logic                    flush;
    logic                    load;

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    assign bus.imem_addr = pc_p0;

    // JMP is resolved here from the raw ROM word, before decode sees it
    assign is_jmp     = (bus.imem_ins[OP_MSB:OP_LSB] == OP_JMP);
    assign jmp_off    = PC_W'($signed(bus.imem_ins[JMP_OFF_MSB:0]));
    assign jmp_target = pc_p0 + $unsigned(jmp_off);
    assign past_end   = (32'(pc_p0) >= IMEM_DEPTH);

    assign flush = bus.ex_redirect | (~bus.stall & (halted_q | past_end));
    assign load  = ~flush & ~bus.stall;

    // PC / halt / issue counter state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_p0    <= PC_W'(RESET_PC);
            halted_q <= 1'b0;
            count_q  <= '0;
        end else if (bus.ex_redirect) begin
            pc_p0    <= bus.ex_target;
            halted_q <= 1'b0;
        end else if (bus.stall || halted_q) begin
            pc_p0 <= pc_p0;
        end else if (past_end) begin
            halted_q <= 1'b1;
        end else begin
            pc_p0   <= is_jmp ? jmp_target : pc_p0 + 1'b1;
            count_q <= sat_inc(count_q);
        end
    end

    assign bus.halted      = halted_q;
    assign bus.fetch_count = count_q;

    if_id_reg #(
        .PC_W  (PC_W),
        .INS_W (INS_W)
    ) u_if_id (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .hold   (bus.stall),
        .flush  (flush),
        .ins    (bus.imem_ins),
        .pc     (pc_p0),
        .ins_p1 (bus.if_id_ins),
        .pc_p1  (bus.if_id_pc),
        .vld_p1 (bus.if_id_valid)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit driving a 30-word program ROM whose word 28
// jumps back to 21, so execution loops there until redirected.
module tb_fetch_unit;

    logic clk = 1'b0;
    logic rst_n;
    int   compared = 0;
    int   mismatched = 0;

    fetch_unit_if #(.PC_W(16), .INS_W(16)) bus ();

    fetch_unit #(
        .PC_W       (16),
        .INS_W      (16),
        .IMEM_DEPTH (30),
        .RESET_PC   (0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom(input logic [15:0] a);
        if (a == 16'd0)  return 16'h180A;
        if (a == 16'd28) return 16'h37F9;
        if (a == 16'd29) return 16'h0D40;
        if (a < 16'd30)  return 16'h0800 | a;
        return 16'h0000;
    endfunction

    always_comb bus.imem_ins = rom(bus.imem_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        bus.stall = 1'b0;
        bus.ex_redirect = 1'b0;
        bus.ex_target = 16'd0;
        repeat (3) tick();
        chk("rst_addr",  32'(bus.imem_addr), 32'd0);
        chk("rst_valid", 32'(bus.if_id_valid), 32'd0);
        chk("rst_ins",   32'(bus.if_id_ins), 32'd0);
        chk("rst_halt",  32'(bus.halted), 32'd0);
        chk("rst_cnt",   32'(bus.fetch_count), 32'd0);

        rst_n = 1'b1;
        tick();
        chk("f0_ins",   32'(bus.if_id_ins), 32'h180A);
        chk("f0_pc",    32'(bus.if_id_pc), 32'd0);
        chk("f0_valid", 32'(bus.if_id_valid), 32'd1);
        chk("f0_addr",  32'(bus.imem_addr), 32'd1);
        chk("f0_cnt",   32'(bus.fetch_count), 32'd1);

        repeat (4) tick();
        chk("pre_stall_addr", 32'(bus.imem_addr), 32'd5);
        bus.stall = 1'b1;
        repeat (2) tick();
        chk("stall_addr", 32'(bus.imem_addr), 32'd5);
        chk("stall_pc",   32'(bus.if_id_pc), 32'd4);
        chk("stall_ins",  32'(bus.if_id_ins), 32'h0804);
        chk("stall_cnt",  32'(bus.fetch_count), 32'd5);
        bus.stall = 1'b0;
        tick();
        chk("unstall_pc",   32'(bus.if_id_pc), 32'd5);
        chk("unstall_addr", 32'(bus.imem_addr), 32'd6);
        chk("unstall_cnt",  32'(bus.fetch_count), 32'd6);

        repeat (22) tick();
        chk("pre_jmp_addr", 32'(bus.imem_addr), 32'd28);
        chk("pre_jmp_cnt",  32'(bus.fetch_count), 32'd28);
        tick();
        chk("jmp_ins",   32'(bus.if_id_ins), 32'h37F9);
        chk("jmp_pc",    32'(bus.if_id_pc), 32'd28);
        chk("jmp_valid", 32'(bus.if_id_valid), 32'd1);
        chk("jmp_addr",  32'(bus.imem_addr), 32'd21);
        chk("jmp_cnt",   32'(bus.fetch_count), 32'd29);

        tick();
        chk("loop_addr", 32'(bus.imem_addr), 32'd22);
        bus.stall = 1'b1;
        bus.ex_redirect = 1'b1;
        bus.ex_target = 16'd29;
        tick();
        chk("redir_addr",  32'(bus.imem_addr), 32'd29);
        chk("redir_valid", 32'(bus.if_id_valid), 32'd0);
        chk("redir_ins",   32'(bus.if_id_ins), 32'h0000);
        chk("redir_cnt",   32'(bus.fetch_count), 32'd30);
        bus.stall = 1'b0;
        bus.ex_redirect = 1'b0;
        tick();
        chk("f29_ins",  32'(bus.if_id_ins), 32'h0D40);
        chk("f29_pc",   32'(bus.if_id_pc), 32'd29);
        chk("f29_addr", 32'(bus.imem_addr), 32'd30);
        chk("f29_halt", 32'(bus.halted), 32'd0);

        for (int k = 0; k < 2; k++) begin
            tick();
            chk("halt_flag",  32'(bus.halted), 32'd1);
            chk("halt_addr",  32'(bus.imem_addr), 32'd30);
            chk("halt_valid", 32'(bus.if_id_valid), 32'd0);
            chk("halt_cnt",   32'(bus.fetch_count), 32'd31);
        end

        bus.ex_redirect = 1'b1;
        bus.ex_target = 16'd0;
        tick();
        chk("unhalt_flag", 32'(bus.halted), 32'd0);
        chk("unhalt_addr", 32'(bus.imem_addr), 32'd0);
        bus.ex_redirect = 1'b0;

        repeat (28) tick();
        chk("run2_addr", 32'(bus.imem_addr), 32'd28);
        chk("run2_cnt",  32'(bus.fetch_count), 32'd59);
        bus.ex_redirect = 1'b1;
        bus.ex_target = 16'd3;
        tick();
        chk("redir_jmp_addr",  32'(bus.imem_addr), 32'd3);
        chk("redir_jmp_valid", 32'(bus.if_id_valid), 32'd0);
        chk("redir_jmp_cnt",   32'(bus.fetch_count), 32'd59);
        bus.ex_redirect = 1'b0;

        n = 0;
        while (bus.fetch_count != 16'hFFFE && n < 70000) begin
            tick();
            n++;
        end
        chk("cnt_reach", 32'(bus.fetch_count), 32'hFFFE);
        tick();
        chk("cnt_sat1", 32'(bus.fetch_count), 32'hFFFF);
        tick();
        chk("cnt_sat2",  32'(bus.fetch_count), 32'hFFFF);
        chk("sat_valid", 32'(bus.if_id_valid), 32'd1);

        rst_n = 1'b0;
        bus.stall = 1'b1;
        bus.ex_redirect = 1'b1;
        bus.ex_target = 16'd17;
        tick();
        chk("rst2_cnt",   32'(bus.fetch_count), 32'd0);
        chk("rst2_addr",  32'(bus.imem_addr), 32'd0);
        chk("rst2_valid", 32'(bus.if_id_valid), 32'd0);
        chk("rst2_ins",   32'(bus.if_id_ins), 32'd0);
        chk("rst2_halt",  32'(bus.halted), 32'd0);
        rst_n = 1'b1;
        bus.stall = 1'b0;
        bus.ex_redirect = 1'b0;
        tick();
        chk("rst2_f0_ins", 32'(bus.if_id_ins), 32'h180A);
        chk("rst2_f0_cnt", 32'(bus.fetch_count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
